// File: rtl/uart_echo_buffer.sv
// Byte FIFO plus transmit scheduler sitting between the UART receiver and
// transmitter in the loopback path. Received bytes are queued and launched
// to the transmitter one at a time, waiting for each frame to finish.
module uart_echo_buffer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     tx_busy,
  output logic                     tx_en,
  output logic [DATA_W-1:0]        tx_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned TmrW = $clog2(BUSY_TIMEOUT);

  localparam logic [PtrW:0]   DepthCnt  = (PtrW+1)'(DEPTH);
  localparam logic [PtrW:0]   CntOne    = (PtrW+1)'(1);
  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);
  localparam logic [TmrW-1:0] TmrOne    = TmrW'(1);
  localparam logic [TmrW-1:0] TimerLast = TmrW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitBusy,
    StWaitDone
  } state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic [TmrW-1:0]   timer_q;
  logic              overflow_q;
  logic              tx_en_q;
  logic [DATA_W-1:0] tx_data_q;
  state_e            state_q;

  logic full;
  logic empty;
  logic do_push;
  logic do_pop;

  // Full/empty come from the occupancy count; a pop happens only on a launch.
  always_comb begin
    full    = (count_q == DepthCnt);
    empty   = (count_q == '0);
    do_push = rx_valid && !full;
    do_pop  = (state_q == StIdle) && !empty && !tx_busy;
  end

  // Byte storage; contents need no reset since count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      // Full is judged on the pre-pop count, so a same-cycle pop cannot save the byte.
      if (rx_valid && full) begin
        overflow_q <= 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // Launch scheduler with registered tx_en/tx_data.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      timer_q   <= '0;
    end else begin
      tx_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (do_pop) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= mem_q[rd_ptr_q];
            timer_q   <= '0;
            state_q   <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          // Give up on a transmitter that never raises busy.
          if (tx_busy) begin
            state_q <= StWaitDone;
          end else if (timer_q == TimerLast) begin
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + TmrOne;
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign fifo_count = count_q;
  assign fifo_full  = full;
  assign fifo_empty = empty;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Bench for uart_echo_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based model through a launch scoreboard.
module tb_uart_echo_buffer;

  localparam int unsigned DEPTH        = 16;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned BUSY_TIMEOUT = 8;

  logic                   clk_i = 1'b0;
  logic                   rst = 1'b1;
  logic                   rx_valid = 1'b0;
  logic [DATA_W-1:0]      rx_data = '0;
  logic                   tx_busy;
  logic                   tx_en;
  logic [DATA_W-1:0]      tx_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   overflow;

  uart_echo_buffer #(
    .DEPTH(DEPTH),
    .DATA_W(DATA_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk_i(clk_i),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_busy(tx_busy),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .fifo_count(fifo_count),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .overflow(overflow)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [DATA_W-1:0] m_q[$];     // bytes accepted but not yet launched
  logic [DATA_W-1:0] exp_q[$];   // scoreboard: launches awaiting the monitor
  bit                m_armed = 1'b1;
  bit                m_seen = 1'b0;
  int                m_waited = 0;
  bit                m_en = 1'b0;
  logic [DATA_W-1:0] m_last = '0;
  bit                m_ovf = 1'b0;
  bit                m_live = 1'b0;

  // Transmitter behaviour: 0 never busy, 1 held busy, 2 responds to launches.
  int tx_mode = 0;
  int dly_lo = 1, dly_hi = 1, len_lo = 4, len_hi = 4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter stand-in.
  initial begin
    int pend;
    int left;
    pend = 0;
    left = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      if (tx_mode == 0) begin
        tx_busy = 1'b0;
        pend = 0;
        left = 0;
      end else if (tx_mode == 1) begin
        tx_busy = 1'b1;
        pend = 0;
        left = 0;
      end else begin
        if (tx_en === 1'b1) begin
          pend = $urandom_range(dly_hi, dly_lo);
          left = $urandom_range(len_hi, len_lo);
        end
        if (pend > 0) begin
          pend--;
          tx_busy = 1'b0;
        end else if (left > 0) begin
          left--;
          tx_busy = 1'b1;
        end else begin
          tx_busy = 1'b0;
        end
      end
    end
  end

  // Reference model: after each launch, launching is re-armed once busy has
  // risen and fallen again, or after BUSY_TIMEOUT cycles with no busy at all.
  initial begin
    int  pre;
    bit  launch;
    forever begin
      @(posedge clk_i);
      if (rst) begin
        m_q.delete();
        m_armed = 1'b1;
        m_seen  = 1'b0;
        m_waited = 0;
        m_en    = 1'b0;
        m_last  = '0;
        m_ovf   = 1'b0;
        m_live  = 1'b1;
      end else begin
        pre    = m_q.size();
        launch = m_armed && (pre > 0) && !tx_busy;
        m_en   = launch;
        if (launch) begin
          m_last = m_q.pop_front();
          exp_q.push_back(m_last);
          m_armed  = 1'b0;
          m_seen   = 1'b0;
          m_waited = 0;
        end else if (!m_armed) begin
          if (!m_seen) begin
            if (tx_busy) begin
              m_seen = 1'b1;
            end else begin
              m_waited++;
              if (m_waited == BUSY_TIMEOUT) m_armed = 1'b1;
            end
          end else if (!tx_busy) begin
            m_armed = 1'b1;
          end
        end
        if (rx_valid) begin
          if (pre < DEPTH) m_q.push_back(rx_data);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Monitor: compares registered outputs and pops the scoreboard on launches.
  initial begin
    forever begin
      @(negedge clk_i);
      if (m_live) begin
        chk("tx_en", {31'b0, tx_en}, {31'b0, m_en});
        chk("tx_data_hold", {24'b0, tx_data}, {24'b0, m_last});
        chk("fifo_count", {27'b0, fifo_count}, m_q.size());
        chk("fifo_full", {31'b0, fifo_full}, {31'b0, m_q.size() == DEPTH});
        chk("fifo_empty", {31'b0, fifo_empty}, {31'b0, m_q.size() == 0});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        if (tx_en === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL launch_order: got %0h expected none at %0t", tx_data, $time);
          end else begin
            chk("launch_order", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_tx(input int lo_d, input int hi_d, input int lo_l, input int hi_l);
    dly_lo = lo_d;
    dly_hi = hi_d;
    len_lo = lo_l;
    len_hi = hi_l;
    tx_mode = 2;
  endtask

  // Wait (bounded) until everything queued has been launched and observed.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(m_q.size() == 0 && exp_q.size() == 0 && m_armed && !tx_busy) && n < 3000) begin
      step();
      n++;
    end
    n_tests++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL drain_%s: got %0d pending expected 0", name, m_q.size() + exp_q.size());
    end
  endtask

  initial begin
    int p;
    // Single byte with a transmitter that answers one cycle after launch.
    set_tx(1, 1, 100, 100);
    step();
    step();
    do_reset();
    repeat (7) step();
    send(8'h55);
    drain("single");

    // Burst of 5 while busy is held, then released.
    tx_mode = 1;
    step();
    for (int i = 1; i <= 5; i++) send(DATA_W'(i));
    repeat (4) step();
    set_tx(1, 1, 5, 5);
    drain("burst");

    // Overflow: 18 bytes into a 16-deep buffer while held busy.
    tx_mode = 1;
    step();
    for (int i = 0; i < 18; i++) send(DATA_W'(i));
    repeat (3) step();
    set_tx(1, 1, 3, 3);
    drain("overflow");

    // Same-cycle push and pop at count=1.
    do_reset();
    tx_mode = 1;
    step();
    send(8'hA1);
    step();
    set_tx(1, 1, 3, 3);
    send(8'hA2);
    drain("pushpop1");

    // Same-cycle push and pop at count=DEPTH: the pushed byte is dropped.
    tx_mode = 1;
    step();
    for (int i = 0; i < DEPTH; i++) send(DATA_W'(8'h40 + i));
    set_tx(1, 1, 2, 2);
    send(8'hEE);
    drain("pushpopfull");

    // Busy timeout: transmitter never answers.
    do_reset();
    tx_mode = 0;
    send(8'h31);
    send(8'h32);
    send(8'h33);
    drain("timeout");

    // Reset while waiting for a long frame to finish.
    set_tx(1, 1, 40, 40);
    for (int i = 0; i < 4; i++) send(DATA_W'(8'hC0 + i));
    repeat (6) step();
    do_reset();
    repeat (60) step();
    drain("midreset");

    // Randomized traffic with varying load and transmitter behaviour.
    for (int blk = 0; blk < 6; blk++) begin
      unique case (blk % 3)
        0: p = 5;
        1: p = 30;
        default: p = 80;
      endcase
      if (blk == 4) tx_mode = 0;
      else set_tx(0, 10, 1, 12);
      for (int c = 0; c < 500; c++) begin
        rx_valid = ($urandom_range(99, 0) < p);
        rx_data  = DATA_W'($urandom);
        step();
      end
      rx_valid = 1'b0;
    end
    set_tx(1, 1, 3, 3);
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
